// File: rtl/ram64_delay_line.sv
// Sample-count delay line over per-bit 64x1 single-port LUTRAM cells sharing one address.
// Returns the sample accepted LEN+1 accepts earlier, flagged valid only once the line has filled.

module ram64x1s (
    input  logic       wclk,
    input  logic [5:0] a,
    input  logic       d,
    input  logic       we,
    output logic       o_c
);

    logic [63:0] mem;

    // Storage is intentionally never reset; validity is tracked by the fill logic.
    always_ff @(posedge wclk) begin
        if (we) begin
            mem[a] <= d;
        end
    end

    assign o_c = mem[a];

endmodule

module ram64_delay_line #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       LEN,
    input  logic             LEN_LD,
    input  logic             VLD_IN,
    input  logic [WIDTH-1:0] D_IN,
    output logic             VLD_OUT,
    output logic [WIDTH-1:0] D_OUT,
    output logic             FILLED
);

    localparam int unsigned AW = 6;
    localparam int unsigned CW = 7;

    logic [AW-1:0]    len_r;
    logic [AW-1:0]    ptr;
    logic [CW-1:0]    fill_cnt;
    logic             we_c;
    logic [WIDTH-1:0] rd_c;
    logic [CW-1:0]    depth_c;
    logic [AW-1:0]    ptr_nxt_c;
    logic [CW-1:0]    fill_inc_c;

    assign we_c       = VLD_IN & ~RST & ~LEN_LD;
    assign depth_c    = CW'(len_r) + CW'(1);
    assign ptr_nxt_c  = (ptr == len_r) ? '0 : ptr + AW'(1);
    assign fill_inc_c = fill_cnt + CW'(1);

    // One LUTRAM cell per data bit, all on the shared pointer address.
    for (genvar b = 0; b < int'(WIDTH); b++) begin : gen_bit
        ram64x1s u_cell (
            .wclk (CLK),
            .a    (ptr),
            .d    (D_IN[b]),
            .we   (we_c),
            .o_c  (rd_c[b])
        );
    end

    // Control and output registers; priority RST > LEN_LD > accept > idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_r    <= LEN;
            ptr      <= '0;
            fill_cnt <= '0;
            FILLED   <= 1'b0;
            VLD_OUT  <= 1'b0;
            D_OUT    <= '0;
        end else if (LEN_LD) begin
            len_r    <= LEN;
            ptr      <= '0;
            fill_cnt <= '0;
            FILLED   <= 1'b0;
            VLD_OUT  <= 1'b0;
        end else if (VLD_IN) begin
            D_OUT   <= rd_c;
            ptr     <= ptr_nxt_c;
            VLD_OUT <= FILLED;
            if (fill_cnt < depth_c) begin
                fill_cnt <= fill_inc_c;
            end
            if (fill_inc_c == depth_c) begin
                FILLED <= 1'b1;
            end
        end else begin
            VLD_OUT <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram64_delay_line.sv
// Randomized + directed scoreboard bench for ram64_delay_line against a queue-based history model.

module tb_ram64_delay_line;

    logic       CLK;
    logic       RST;
    logic [5:0] LEN;
    logic       LEN_LD;
    logic       VLD_IN;
    logic [7:0] D_IN;
    logic       VLD_OUT;
    logic [7:0] D_OUT;
    logic       FILLED;

    ram64_delay_line #(.WIDTH(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .LEN     (LEN),
        .LEN_LD  (LEN_LD),
        .VLD_IN  (VLD_IN),
        .D_IN    (D_IN),
        .VLD_OUT (VLD_OUT),
        .D_OUT   (D_OUT),
        .FILLED  (FILLED)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: history of samples accepted since last reset/load.
    logic [7:0] hist[$];
    logic [7:0] sb_q[$];
    int         n_acc   = 0;
    int         mlen    = 0;
    bit         e_vld   = 0;
    bit         e_fill  = 0;
    logic [7:0] e_dout  = 8'h00;
    bit         d_known = 0;
    bit         mon_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ld, input logic [5:0] len,
                              input bit v, input logic [7:0] d);
        if (rst || ld) begin
            mlen = int'(len);
            hist.delete();
            n_acc  = 0;
            e_fill = 0;
            e_vld  = 0;
            if (rst) begin
                e_dout  = 8'h00;
                d_known = 1;
                mon_en  = 1;
            end
        end else if (v) begin
            if (n_acc >= mlen + 1) begin
                e_dout  = hist[n_acc - (mlen + 1)];
                e_vld   = 1;
                d_known = 1;
                sb_q.push_back(e_dout);
            end else begin
                e_vld   = 0;
                d_known = 0;
            end
            hist.push_back(d);
            n_acc++;
            e_fill = (n_acc >= mlen + 1);
        end else begin
            e_vld = 0;
        end
    endtask

    task automatic step(input bit rst, input bit ld, input logic [5:0] len,
                        input bit v, input logic [7:0] d);
        RST = rst; LEN_LD = ld; LEN = len; VLD_IN = v; D_IN = d;
        @(posedge CLK);
        model_edge(rst, ld, len, v, d);
        #1;
    endtask

    function automatic logic [5:0] rlen();
        return 6'($urandom_range(0, 63));
    endfunction

    // Monitor: sample away from the active edge and drain the scoreboard on each valid output.
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                chk("vld_out", 32'(VLD_OUT), 32'(e_vld));
                chk("filled", 32'(FILLED), 32'(e_fill));
                if (d_known) chk("d_out_state", 32'(D_OUT), 32'(e_dout));
                if (VLD_OUT === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected at %0t: got d_out %0h expected no output", $time, D_OUT);
                    end else begin
                        chk("sb_data", 32'(D_OUT), 32'(sb_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        RST = 1'b0; LEN_LD = 1'b0; LEN = '0; VLD_IN = 1'b0; D_IN = '0;

        // Delay-4 stream; LEN input wiggles to show it is ignored without a load.
        step(1, 0, 6'd3, 0, 8'h00);
        for (int i = 1; i <= 20; i++) step(0, 0, rlen(), 1, 8'(i));

        // Full depth with pointer wrap.
        step(1, 0, 6'd63, 0, 8'h00);
        for (int i = 0; i < 200; i++) step(0, 0, rlen(), 1, 8'(i));

        // Minimum delay.
        step(1, 0, 6'd0, 0, 8'h00);
        step(0, 0, 6'd9, 1, 8'hA5);
        step(0, 0, 6'd9, 1, 8'h5A);
        step(0, 0, 6'd9, 1, 8'h3C);
        step(0, 0, 6'd9, 0, 8'h00);

        // Bubbles between accepts.
        step(1, 0, 6'd2, 0, 8'h00);
        for (int i = 10; i <= 13; i++) begin
            step(0, 0, 6'd2, 1, 8'(i));
            for (int k = 0; k < 3; k++) step(0, 0, 6'd2, 0, 8'($urandom));
        end

        // Mid-stream reload with a colliding sample that must be dropped.
        step(1, 0, 6'd7, 0, 8'h00);
        for (int i = 0; i < 10; i++) step(0, 0, 6'd7, 1, 8'(8'h40 + i));
        step(0, 1, 6'd1, 1, 8'hFF);
        step(0, 0, 6'd1, 1, 8'h01);
        step(0, 0, 6'd1, 1, 8'h02);
        step(0, 0, 6'd1, 1, 8'h03);
        step(0, 0, 6'd1, 1, 8'h04);

        // Reset during a continuous stream; stale RAM must not appear valid.
        step(1, 0, 6'd5, 0, 8'h00);
        for (int i = 0; i < 15; i++) step(0, 0, 6'd5, 1, 8'(8'h80 + i));
        step(1, 0, 6'd5, 1, 8'h99);
        for (int i = 0; i < 10; i++) step(0, 0, 6'd5, 1, 8'(8'hC0 + i));

        // Random traffic with occasional loads and resets.
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            logic [5:0]  l;
            r = $urandom_range(0, 999);
            l = ($urandom_range(0, 7) == 0) ? rlen() : 6'($urandom_range(0, 12));
            step(r < 4, (r >= 4 && r < 12), l, ($urandom_range(0, 9) < 7), 8'($urandom));
        end

        for (int i = 0; i < 3; i++) step(0, 0, 6'd0, 0, 8'h00);
        @(negedge CLK);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
